// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins plus local TX/RX handshake bundle for spi_slave.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SCLK;
  logic                  SS;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_OE;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  BUSY;

  modport slave (
    input  SCLK, SS, MOSI, TX_DATA, TX_VALID,
    output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY
  );

  modport master (
    output SCLK, SS, MOSI, TX_DATA, TX_VALID,
    input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI target with one-word TX holding buffer.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);
  localparam int   CW       = $clog2(DATA_WIDTH);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_d1_q, sclk_d1_d;
  logic                    ss_d1_q, ss_d1_d;
  logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic                    tx_full_q, tx_full_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    busy_q, busy_d;

  logic                    sclk_s, ss_s, mosi_s;
  logic                    ss_fall, ss_rise, lead_edge, trail_edge;
  logic                    sample_edge, drive_edge;
  logic                    load;
  logic [DATA_WIDTH-1:0]   word_load;
  logic [DATA_WIDTH-1:0]   rx_next;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_d1_d   = sclk_s;
    ss_d1_d     = ss_s;
    ss_fall     = ss_d1_q && !ss_s;
    ss_rise     = !ss_d1_q && ss_s;
    lead_edge   = (sclk_d1_q == IDLE_LVL) && (sclk_s != IDLE_LVL);
    trail_edge  = (sclk_d1_q != IDLE_LVL) && (sclk_s == IDLE_LVL);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    drive_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  end

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    load       = 1'b0;
    word_load  = tx_full_q ? tx_buf_q : '0;
    rx_next    = {rx_shift_q, mosi_s};

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
          // Mode with leading-edge sampling needs the MSB on the pin before the first edge.
          if (CPHA == 0) begin
            miso_d     = word_load[DATA_WIDTH-1];
            tx_shift_d = word_load << 1;
          end else begin
            tx_shift_d = word_load;
          end
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_next[DATA_WIDTH-2:0];
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_shift_d = word_load;
            load       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (drive_edge) begin
          miso_d     = tx_shift_q[DATA_WIDTH-1];
          tx_shift_d = tx_shift_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write can only coincide with a load when the buffer is empty, so the load sees zeros.
    if (load) begin
      tx_full_d = 1'b0;
    end
    if (bus.TX_VALID && !tx_full_q) begin
      tx_buf_d  = bus.TX_DATA;
      tx_full_d = 1'b1;
    end

    miso_oe_d = (state_d == ACTIVE);
    busy_d    = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_d1_q   <= IDLE_LVL;
      ss_d1_q     <= 1'b1;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_d1_q   <= sclk_d1_d;
      ss_d1_q     <= ss_d1_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.MISO_OE  = miso_oe_q;
  assign bus.TX_READY = !tx_full_q;
  assign bus.RX_DATA  = rx_data_q;
  assign bus.RX_VALID = rx_valid_q;
  assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - bench for spi_slave: one DUT per SPI mode driven by a bit-banged master.
module tb_spi_slave;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sclk_pin [4];
  logic         ss_pin [4];
  logic         mosi_pin [4];
  logic         tx_valid_pin [4];
  logic [W-1:0] tx_data_pin [4];
  logic         miso_w [4];
  logic         oe_w [4];
  logic         ready_w [4];
  logic         rxv_w [4];
  logic         busy_w [4];
  logic [W-1:0] rxd_w [4];

  int           rxv_cnt [4] = '{0, 0, 0, 0};
  logic [W-1:0] rx_last [4] = '{0, 0, 0, 0};
  logic [W-1:0] rx_prev [4] = '{0, 0, 0, 0};
  int           errors = 0;
  int           checks = 0;

  // Reference: the word a load hands out is whatever the host last wrote and nobody took yet, else zero.
  bit           mhas [4];
  logic [W-1:0] mword [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_if #(.DATA_WIDTH(W)) bus ();
    assign bus.SCLK     = sclk_pin[g];
    assign bus.SS       = ss_pin[g];
    assign bus.MOSI     = mosi_pin[g];
    assign bus.TX_DATA  = tx_data_pin[g];
    assign bus.TX_VALID = tx_valid_pin[g];
    assign miso_w[g]    = bus.MISO;
    assign oe_w[g]      = bus.MISO_OE;
    assign ready_w[g]   = bus.TX_READY;
    assign rxv_w[g]     = bus.RX_VALID;
    assign busy_w[g]    = bus.BUSY;
    assign rxd_w[g]     = bus.RX_DATA;
    spi_slave #(.DATA_WIDTH(W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rxv_w[k] === 1'b1) begin
        rxv_cnt[k] <= rxv_cnt[k] + 1;
        rx_prev[k] <= rx_last[k];
        rx_last[k] <= rxd_w[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_load(input int m);
    logic [W-1:0] w;
    w = mhas[m] ? mword[m] : '0;
    mhas[m] = 1'b0;
    return w;
  endfunction

  task automatic hp();
    repeat (5) @(negedge clk);
  endtask

  task automatic host_write(input int m, input logic [W-1:0] d);
    int t;
    t = 0;
    tx_data_pin[m]  = d;
    tx_valid_pin[m] = 1'b1;
    while (ready_w[m] !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("m%0d_tx_ready_wait", m), 32'(t < 64), 32'd1);
    @(negedge clk);
    tx_valid_pin[m] = 1'b0;
    mhas[m]  = 1'b1;
    mword[m] = d;
  endtask

  task automatic ss_low(input int m);
    ss_pin[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high(input int m);
    hp();
    ss_pin[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int m, input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    logic cpol, cpha;
    cpol = (m / 2) != 0;
    cpha = (m % 2) != 0;
    rx = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      if (!cpha) begin
        mosi_pin[m] = tx[i];
        hp();
        rx = {rx[W-2:0], miso_w[m]};
        sclk_pin[m] = ~cpol;
        hp();
        sclk_pin[m] = cpol;
      end else begin
        sclk_pin[m] = ~cpol;
        mosi_pin[m] = tx[i];
        hp();
        rx = {rx[W-2:0], miso_w[m]};
        sclk_pin[m] = cpol;
        hp();
      end
    end
  endtask

  task automatic word_frame(input int m, input logic [W-1:0] mo, input string tag);
    logic [W-1:0] exp_tx, got;
    int c0;
    c0 = rxv_cnt[m];
    exp_tx = model_load(m);
    ss_low(m);
    chk($sformatf("m%0d_%s_busy", m, tag), 32'(busy_w[m]), 32'd1);
    chk($sformatf("m%0d_%s_oe", m, tag), 32'(oe_w[m]), 32'd1);
    chk($sformatf("m%0d_%s_ready_in", m, tag), 32'(ready_w[m]), 32'd1);
    xfer(m, mo, W, got);
    void'(model_load(m));
    ss_high(m);
    chk($sformatf("m%0d_%s_miso_word", m, tag), 32'(got), 32'(exp_tx));
    chk($sformatf("m%0d_%s_rx_data", m, tag), 32'(rxd_w[m]), 32'(mo));
    chk($sformatf("m%0d_%s_rx_pulses", m, tag), 32'(rxv_cnt[m] - c0), 32'd1);
    chk($sformatf("m%0d_%s_idle", m, tag), {29'd0, busy_w[m], oe_w[m], ready_w[m]}, 32'b001);
  endtask

  task automatic abort_frame(input int m);
    logic [W-1:0] d, e, got;
    int c0;
    d = 8'($urandom);
    host_write(m, d);
    c0 = rxv_cnt[m];
    e = model_load(m);
    ss_low(m);
    xfer(m, 8'($urandom), 5, got);
    ss_pin[m] = 1'b1;
    repeat (4) @(negedge clk);
    chk($sformatf("m%0d_abort_busy", m), 32'(busy_w[m]), 32'd0);
    chk($sformatf("m%0d_abort_oe", m), 32'(oe_w[m]), 32'd0);
    repeat (8) @(negedge clk);
    chk($sformatf("m%0d_abort_no_rxv", m), 32'(rxv_cnt[m] - c0), 32'd0);
    chk($sformatf("m%0d_abort_partial", m), 32'(got[4:0]), 32'(e[7:3]));
    host_write(m, 8'($urandom));
    word_frame(m, 8'($urandom), "post_abort");
  endtask

  initial begin
    logic [W-1:0] g1, g2, e1, e2;
    int c0;
    for (int k = 0; k < 4; k++) begin
      sclk_pin[k]     = (k / 2) != 0;
      ss_pin[k]       = 1'b1;
      mosi_pin[k]     = 1'b0;
      tx_valid_pin[k] = 1'b0;
      tx_data_pin[k]  = '0;
      mhas[k]         = 1'b0;
      mword[k]        = '0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m%0d_rst_outs", k),
          {26'd0, miso_w[k], oe_w[k], rxv_w[k], busy_w[k], ready_w[k], 1'b0}, 32'b000010);
      chk($sformatf("m%0d_rst_rx_data", k), 32'(rxd_w[k]), 32'd0);
    end

    for (int m = 0; m < 4; m++) begin
      host_write(m, (m == 0) ? 8'hA5 : 8'h81);
      word_frame(m, (m == 0) ? 8'h3C : 8'h7E, "named");
      for (int r = 0; r < 3; r++) begin
        if ($urandom_range(0, 1) == 1) host_write(m, 8'($urandom));
        word_frame(m, 8'($urandom), "rand");
      end
    end

    word_frame(0, 8'h96, "underrun");

    host_write(0, 8'h11);
    c0 = rxv_cnt[0];
    e1 = model_load(0);
    ss_low(0);
    host_write(0, 8'h22);
    xfer(0, 8'hF0, W, g1);
    e2 = model_load(0);
    xfer(0, 8'h0F, W, g2);
    void'(model_load(0));
    ss_high(0);
    chk("two_word_miso0", 32'(g1), 32'(e1));
    chk("two_word_miso1", 32'(g2), 32'(e2));
    chk("two_word_pulses", 32'(rxv_cnt[0] - c0), 32'd2);
    chk("two_word_rx0", 32'(rx_prev[0]), 32'hF0);
    chk("two_word_rx1", 32'(rx_last[0]), 32'h0F);

    abort_frame(0);
    abort_frame(3);

    host_write(0, 8'($urandom));
    void'(model_load(0));
    c0 = rxv_cnt[0];
    ss_low(0);
    xfer(0, 8'hFF, 3, g1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {27'd0, miso_w[0], oe_w[0], rxv_w[0], busy_w[0], ready_w[0]}, 32'b00001);
    chk("rst_mid_rx_data", 32'(rxd_w[0]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mhas[k] = 1'b0;
    repeat (4) @(negedge clk);
    ss_pin[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_rxv", 32'(rxv_cnt[0] - c0), 32'd0);
    host_write(0, 8'hC3);
    word_frame(0, 8'h5A, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
